pipeline_foreground_fetch: RTL and testbench

PIPELINE_FOREGROUND_FETCH -- requirements
Module: pipeline_foreground_fetch

---
 rtl/pipeline_foreground_fetch.sv | 118 +++++++++++
 tb/tb_pipeline_foreground_fetch.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_foreground_fetch.sv
// Foreground pixel fetch: fixed-latency SRAM reads for the render pipeline, with
// frame writes queued in a small FIFO and issued only in slots no read needs.
module pipeline_foreground_fetch #(
  parameter int FETCH_LATENCY = 4,
  parameter int WFIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  req_x,
  input  logic [9:0]  req_y,
  input  logic        req_active,
  output logic [15:0] fg_pixel_out,
  output logic        fg_pixel_skip,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [9:0]  wr_x,
  input  logic [9:0]  wr_y,
  input  logic [15:0] wr_data,
  output logic        wr_overflow,
  output logic [18:0] sram_addr,
  output logic        sram_we_n,
  output logic        sram_oe_n,
  output logic [15:0] sram_data_out,
  output logic        sram_data_oe,
  input  logic [15:0] sram_data_in
);

  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(WFIFO_DEPTH);

  logic          read_slot;
  logic [18:0]   req_addr;
  logic          wr_in_range;
  logic          push;
  logic          pop;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic [34:0]   fifo_mem [WFIFO_DEPTH];
  logic [1:0]    rd_vld;
  logic [16:0]   pipe [FETCH_LATENCY-1];

  assign read_slot   = req_active && (req_x < 10'd640) && (req_y < 10'd480);
  assign req_addr    = {req_y[8:0], req_x};
  assign wr_in_range = (wr_x < 10'd640) && (wr_y < 10'd480);

  // Write handshake: a transfer happens on an edge where wr_valid && wr_ready;
  // wr_ready depends only on occupancy, never on wr_valid. Out-of-range
  // transfers complete the handshake but are dropped instead of queued.
  assign wr_ready = (count != FULL_COUNT);
  assign push     = wr_valid && wr_ready && wr_in_range;
  assign pop      = !read_slot && (count != '0);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= {wr_y[8:0], wr_x, wr_data};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      wr_overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_valid && !wr_ready) wr_overflow <= 1'b1;
    end
  end

  // One SRAM bus cycle per edge: a read if requested, else the oldest write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_addr     <= '0;
      sram_we_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_data_oe  <= 1'b0;
      sram_data_out <= '0;
    end else if (read_slot) begin
      sram_addr    <= req_addr;
      sram_oe_n    <= 1'b0;
      sram_we_n    <= 1'b1;
      sram_data_oe <= 1'b0;
    end else if (pop) begin
      {sram_addr, sram_data_out} <= fifo_mem[rptr];
      sram_we_n    <= 1'b0;
      sram_oe_n    <= 1'b1;
      sram_data_oe <= 1'b1;
    end else begin
      sram_we_n    <= 1'b1;
      sram_oe_n    <= 1'b1;
      sram_data_oe <= 1'b0;
    end
  end

  // rd_vld[1] marks that sram_data_in belongs to a read at this edge; the
  // result then rides pipe[] so every request lands exactly FETCH_LATENCY later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld <= '0;
      for (int i = 0; i < FETCH_LATENCY - 1; i++) pipe[i] <= {1'b1, 16'h0000};
    end else begin
      rd_vld  <= {rd_vld[0], read_slot};
      pipe[0] <= {!rd_vld[1], rd_vld[1] ? sram_data_in : 16'h0000};
      for (int i = 1; i < FETCH_LATENCY - 1; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign fg_pixel_skip = pipe[FETCH_LATENCY-2][16];
  assign fg_pixel_out  = pipe[FETCH_LATENCY-2][15:0];

endmodule

// File: tb/tb_pipeline_foreground_fetch.sv
// Bench for pipeline_foreground_fetch: directed scenarios then random traffic,
// against an SRAM model, an expected-result queue and an expected-write queue.
module tb_pipeline_foreground_fetch;

  localparam int L = 4;
  localparam int D = 8;

  logic        clk;
  logic        rst;
  logic [9:0]  req_x, req_y;
  logic        req_active;
  logic [15:0] fg_pixel_out;
  logic        fg_pixel_skip;
  logic        wr_valid;
  logic        wr_ready;
  logic [9:0]  wr_x, wr_y;
  logic [15:0] wr_data;
  logic        wr_overflow;
  logic [18:0] sram_addr;
  logic        sram_we_n, sram_oe_n;
  logic [15:0] sram_data_out;
  logic        sram_data_oe;
  logic [15:0] sram_data_in;

  int n_checks = 0;
  int n_fail   = 0;
  int n_wr_seen = 0;
  logic mon_en = 1'b0;
  logic track_mem = 1'b0;

  logic [16:0] exp_q[$];
  logic [34:0] exp_wq[$];
  logic [15:0] sram_mem  [logic [18:0]];
  logic [15:0] model_pre [logic [18:0]];
  logic [15:0] model_mem [logic [18:0]];

  pipeline_foreground_fetch #(.FETCH_LATENCY(L), .WFIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_x(req_x), .req_y(req_y), .req_active(req_active),
    .fg_pixel_out(fg_pixel_out), .fg_pixel_skip(fg_pixel_skip),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_overflow(wr_overflow), .sram_addr(sram_addr),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n), .sram_data_out(sram_data_out),
    .sram_data_oe(sram_data_oe), .sram_data_in(sram_data_in)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pattern(input logic [18:0] a);
    return a[15:0] ^ 16'hA5A5 ^ {13'h0, a[18:16]};
  endfunction

  function automatic logic [15:0] model_read(input logic [18:0] a);
    return model_pre.exists(a) ? model_pre[a] : pattern(a);
  endfunction

  // SRAM model: write on a we_n cycle, read data valid one cycle after address
  always @(posedge clk) begin
    if (sram_we_n === 1'b0) sram_mem[sram_addr] = sram_data_out;
    if (sram_oe_n === 1'b0)
      sram_data_in <= sram_mem.exists(sram_addr) ? sram_mem[sram_addr] : pattern(sram_addr);
    else
      sram_data_in <= 16'hDEAD;
  end

  task automatic check(input string tag, input logic [34:0] obs, input logic [34:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus monitor: pad-driver/read-enable exclusion and in-order write checking
  always @(negedge clk) begin
    if (mon_en) begin
      check("oe_conflict", 35'(sram_data_oe && !sram_oe_n), 35'(0));
      if (sram_we_n === 1'b0) begin
        n_wr_seen++;
        if (exp_wq.size() == 0) check("spurious_write", 35'({sram_addr, sram_data_out}), 35'h7_FFFF_FFFF);
        else check("write_addr_data", 35'({sram_addr, sram_data_out}), exp_wq.pop_front());
      end
    end
  end

  task automatic prefill();
    exp_q.delete();
    for (int i = 0; i < L; i++) exp_q.push_back(17'h10000);
  endtask

  task automatic check_reset_vals();
    check("rst_pixel", 35'({fg_pixel_skip, fg_pixel_out}), 35'(17'h10000));
    check("rst_sram",  35'({sram_addr, sram_we_n, sram_oe_n, sram_data_oe}), 35'({19'h0, 3'b110}));
    check("rst_wdata", 35'(sram_data_out), 35'(0));
    check("rst_wr",    35'({wr_ready, wr_overflow}), 35'(2'b10));
  endtask

  // Driver: one request and one write offer per cycle, with per-cycle checks
  task automatic step(input logic ra, input logic [9:0] rx, input logic [9:0] ry,
                      input logic wv, input logic [9:0] wx, input logic [9:0] wy,
                      input logic [15:0] wd);
    logic rd, acc;
    logic [18:0] a;
    logic [16:0] e;
    req_active = ra; req_x = rx; req_y = ry;
    wr_valid = wv; wr_x = wx; wr_y = wy; wr_data = wd;
    rd  = ra && (rx < 640) && (ry < 480);
    a   = {ry[8:0], rx};
    acc = wv && wr_ready;
    @(posedge clk);
    exp_q.push_back(rd ? {1'b0, model_read(a)} : 17'h10000);
    if (acc && (wx < 640) && (wy < 480)) begin
      exp_wq.push_back({wy[8:0], wx, wd});
      if (track_mem) model_mem[{wy[8:0], wx}] = wd;
    end
    #1;
    e = exp_q.pop_front();
    check("pixel", 35'({fg_pixel_skip, fg_pixel_out}), 35'(e));
    if (rd) check("read_cycle", 35'({sram_addr, sram_oe_n, sram_we_n, sram_data_oe}), 35'({a, 3'b010}));
    else    check("no_read", 35'(sram_oe_n), 35'(1));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 10'd0, 10'd0, 1'b0, 10'd0, 10'd0, 16'h0);
  endtask

  initial begin
    int base;
    rst = 1'b1; req_active = 1'b0; req_x = '0; req_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    sram_mem[19'h00803]  = 16'hF800;
    model_pre[19'h00803] = 16'hF800;
    repeat (2) @(posedge clk);
    #2 check_reset_vals();
    rst = 1'b0;
    mon_en = 1'b1;
    prefill();

    // Single read at (3,2) returning F800
    step(1'b1, 10'd3, 10'd2, 1'b0, 10'd0, 10'd0, 16'h0);
    check("req033_addr", 35'(sram_addr), 35'(19'h00803));
    idle(L);

    // Inactive and out-of-range requests produce skips
    step(1'b0, 10'd3, 10'd2, 1'b0, 10'd0, 10'd0, 16'h0);
    step(1'b1, 10'd640, 10'd0, 1'b0, 10'd0, 10'd0, 16'h0);
    step(1'b1, 10'd0, 10'd480, 1'b0, 10'd0, 10'd0, 16'h0);
    idle(L);

    // Two writes queued behind continuous reads, then drained in order
    base = n_wr_seen;
    step(1'b1, 10'd10, 10'd3, 1'b1, 10'd1, 10'd1, 16'h1234);
    step(1'b1, 10'd10, 10'd4, 1'b1, 10'd2, 10'd1, 16'h5678);
    for (int i = 0; i < 3; i++) step(1'b1, 10'd11, 10'd3, 1'b0, 10'd0, 10'd0, 16'h0);
    check("req035_held", 35'(n_wr_seen - base), 35'(0));
    idle(4);
    check("req035_writes", 35'(n_wr_seen - base), 35'(2));
    check("req035_drained", 35'(exp_wq.size()), 35'(0));

    // Nine back-to-back writes while reading: full after eight, overflow on ninth
    for (int i = 0; i < 9; i++) begin
      check("req036_ready", 35'(wr_ready), 35'(i < D));
      step(1'b1, 10'd20, 10'd5, 1'b1, 10'(i), 10'd300, 16'(16'hC000 + i));
    end
    check("req036_overflow", 35'(wr_overflow), 35'(1));
    idle(12);
    check("req036_drained", 35'(exp_wq.size()), 35'(0));
    check("req036_sticky", 35'({wr_ready, wr_overflow}), 35'(2'b11));

    // Reset with reads in flight and writes queued
    for (int i = 0; i < 5; i++) step(1'b1, 10'd30, 10'd6, 1'b1, 10'(i), 10'd400, 16'(16'hB000 + i));
    step(1'b1, 10'd31, 10'd6, 1'b0, 10'd0, 10'd0, 16'h0);
    rst = 1'b1;
    #1 check_reset_vals();
    exp_wq.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    prefill();
    base = n_wr_seen;
    idle(12);
    check("req037_no_write", 35'(n_wr_seen - base), 35'(0));

    // Random traffic: reads in y<240, writes in y>=240
    track_mem = 1'b1;
    for (int i = 0; i < 10000; i++) begin
      logic ra, wv;
      logic [9:0] rx, ry, wx, wy;
      ra = ($urandom_range(0, 9) < 7);
      rx = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
      ry = ($urandom_range(0, 19) == 0) ? 10'($urandom_range(480, 1023)) : 10'($urandom_range(8, 239));
      wv = ($urandom_range(0, 2) == 0);
      wx = ($urandom_range(0, 9) == 0) ? 10'($urandom_range(640, 1023)) : 10'($urandom_range(0, 639));
      wy = 10'($urandom_range(240, 479));
      step(ra, rx, ry, wv, wx, wy, 16'($urandom));
    end
    for (int i = 0; i < 64 && exp_wq.size() != 0; i++) idle(1);
    check("final_drained", 35'(exp_wq.size()), 35'(0));
    foreach (model_mem[k])
      check("mem_final", 35'(sram_mem.exists(k) ? sram_mem[k] : ~model_mem[k]), 35'(model_mem[k]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
